// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector.
// It watches a qualified serial stream (X sampled while in_valid is high) for a
// pattern of 1..MAX_LEN bits. Overlapping and non-overlapping match modes are
// supported. It produces a registered one-cycle match pulse and keeps a
// saturating match counter. Out of reset it behaves as an overlapping "101"
// detector.
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   cfg_we       load cfg_pattern/cfg_len/cfg_overlap; flushes history
//   cfg_pattern  pattern, bit [len-1] is received first, bit 0 last
//   cfg_len      pattern length (clamped to 1..MAX_LEN on load)
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     qualifies X
//   X            serial data bit
//   cnt_clr      synchronous clear of match_cnt
//   match        registered one-cycle match pulse
//   match_cnt    saturating match count
//   cfg_len_q    active (clamped) pattern length
module seq_pattern_detector #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               X,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   cfg_len_q
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_clamp;
  logic               hit;

  // Candidate history/fill after accepting X, and the hit decision on them
  always_comb begin
    hist_next = {hist_q[MAX_LEN-2:0], X};
    fill_next = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < cfg_len_q);
    end
    // Only the low len_q bits take part in the compare
    hit = in_valid && !cfg_we && (fill_next >= cfg_len_q) &&
          (((hist_next ^ pattern_q) & len_mask) == '0);
  end

  // Length clamp applied when configuration is loaded
  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
  end

  // Configuration, history and match pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= MAX_LEN'(3'b101);
      cfg_len_q <= LEN_W'(3);
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      match     <= 1'b0;
    end else if (cfg_we) begin
      pattern_q <= cfg_pattern;
      cfg_len_q <= len_clamp;
      overlap_q <= cfg_overlap;
      hist_q    <= '0;
      fill_q    <= '0;
      match     <= 1'b0;
    end else if (in_valid) begin
      hist_q <= hist_next;
      // Non-overlapping mode: the next match needs len_q fresh bits
      fill_q <= (hit && !overlap_q) ? '0 : fill_next;
      match  <= hit;
    end else begin
      match <= 1'b0;
    end
  end

  // Saturating match counter; clear wins over a simultaneous increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Runtime-programmable serial bit-pattern detector and the parametrised successor to the fixed "101" FSM detector. It watches a qualified serial bit stream for a pattern of 1..MAX_LEN bits, with overlapping or non-overlapping match mode. It produces a registered one-cycle match pulse and keeps a saturating match counter. It sits on serial input paths (UART/line decode, test stimulus checkers) and comes out of reset configured as the legacy "101" overlapping detector.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match counter

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
cfg_we  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit 0 the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
in_valid  in  1  X is sampled only when high
X  in  1  serial data bit
cnt_clr  in  1  synchronous clear of match_cnt
match  out  1  one-cycle pulse, registered
match_cnt  out  CNT_W  saturating count of matches
cfg_len_q  out  LEN_W  active (clamped) length, for readback

Behaviour:
- Reset (async, rst_n=0). pattern_q = 'b101 zero-extended, len_q = 3, overlap_q = 1. hist = 0, fill = 0, match = 0, match_cnt = 0.
- Internal state:
  - hist: MAX_LEN-bit shift register.
  - fill: 0..MAX_LEN, count of valid bits held in hist since the last flush.
- Config write (cfg_we=1):
  - On the edge, pattern_q, len_q and overlap_q load. len is clamped: 0 -> 1, >MAX_LEN -> MAX_LEN.
  - hist and fill clear to 0 and match goes 0.
  - in_valid in the same cycle is ignored. cfg_we has priority over data.
  - match_cnt is unaffected.
- Data accept (in_valid=1, cfg_we=0):
  - hist_next = {hist[MAX_LEN-2:0], X}.
  - fill_next = min(fill+1, MAX_LEN).
- Hit condition, evaluated on hist_next/fill_next: fill_next >= len_q and hist_next[len_q-1:0] == pattern_q[len_q-1:0]. Bits above len_q are ignored.
- On a hit:
  - match <= 1 at this edge. Latency: match is high in the cycle after the completing bit is presented.
  - match_cnt increments, saturating at 2^CNT_W-1.
  - overlap_q=1: hist/fill update normally, so a suffix can seed the next match.
  - overlap_q=0: fill <= 0, and hist is still shifted. The next match needs len_q fresh bits.
- No hit or no in_valid: match <= 0. match is never high for two cycles off one bit. With in_valid low, hist and fill hold.
- Back-to-back hits on consecutive valid cycles give consecutive match pulses.
- cnt_clr=1: match_cnt <= 0. This wins over a simultaneous increment. The match pulse itself still fires.
- len_q=1: every valid bit equal to pattern_q[0] matches. Non-overlap mode has no further effect.
- Reset mid-stream: all state returns to the reset values immediately, with no partial-match carry-over.

Test Plan:
- After reset, overlap=1, stream X=1,0,1,0,1 (in_valid=1) -> match pulses after the 3rd and 5th bits; match_cnt=2.
- cfg_we with pattern=8'b0000_1101, len=4, overlap=0; stream 1,1,0,1,1,0,1 -> match after bit 4 only (bit 7 completes 1101 but overlaps the first match); match_cnt=1. Repeat with overlap=1 -> matches after bits 4 and 7.
- Pattern 101, in_valid toggling (bits 1, gap, 0, gap, gap, 1) -> single match one cycle after the last valid bit; gaps neither break nor advance detection.
- cfg_len=0 with pattern bit0=1 -> cfg_len_q=1, every valid 1 pulses match. cfg_len=15 with MAX_LEN=8 -> cfg_len_q=8, no match before 8 valid bits.
- CNT_W=2: 5 matches -> match_cnt saturates at 3. cnt_clr asserted on a match cycle -> match=1 that cycle, match_cnt=0.
- Assert rst_n=0 after bits 1,0 of "101", release, send 1 -> no match. cfg_we asserted together with the completing bit -> no match, fill=0.
